// File: rtl/vproc_fpu_lane_join.sv
// vproc_fpu_lane_join: re-joins per-lane FPU results in issue order.
// Per-lane result FIFOs plus a {tag,mask} FIFO; one full-width beat out.
//  clk_i/sync_rst_i  clock, sync active-high reset
//  flush_i           drop all in-flight ops (err_o kept)
//  issue_*           op issue handshake with tag and byte mask
//  lane_*            per-lane result push with ready
//  out_*             joined result beat handshake
//  inflight_o/err_o  ops outstanding / sticky protocol error
module vproc_fpu_lane_join #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned LANE_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 16
) (
  input  logic                        clk_i,
  input  logic                        sync_rst_i,
  input  logic                        flush_i,
  input  logic                        issue_valid_i,
  output logic                        issue_ready_o,
  input  logic [TAG_W-1:0]            issue_tag_i,
  input  logic [LANES*LANE_W/8-1:0]   issue_mask_i,
  input  logic [LANES-1:0]            lane_valid_i,
  output logic [LANES-1:0]            lane_ready_o,
  input  logic [LANES*LANE_W-1:0]     lane_res_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [TAG_W-1:0]            out_tag_o,
  output logic [LANES*LANE_W-1:0]     out_res_o,
  output logic [LANES*LANE_W/8-1:0]   out_mask_o,
  output logic [$clog2(DEPTH):0]      inflight_o,
  output logic                        err_o
);

  localparam int unsigned MW = LANES * LANE_W / 8;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [TAG_W-1:0] tag_mem  [DEPTH];
  logic [MW-1:0]    mask_mem [DEPTH];
  logic [AW-1:0]    tag_wr;
  logic [AW-1:0]    tag_rd;
  logic [CW-1:0]    tag_cnt;

  logic             issue_fire;
  logic             out_fire;
  logic [LANES-1:0] lane_bad;
  logic [LANES-1:0] lane_nempty;

  assign issue_ready_o = (tag_cnt != CW'(DEPTH));
  assign issue_fire    = issue_valid_i & issue_ready_o;
  assign out_valid_o   = (tag_cnt != '0) & (&lane_nempty);
  assign out_fire      = out_valid_o & out_ready_i;
  assign inflight_o    = tag_cnt;
  assign out_tag_o     = tag_mem[tag_rd];
  assign out_mask_o    = mask_mem[tag_rd];

  // The tag FIFO count doubles as the in-flight op count.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i || flush_i) begin
      tag_wr  <= '0;
      tag_rd  <= '0;
      tag_cnt <= '0;
    end else begin
      if (issue_fire) tag_wr <= tag_wr + AW'(1);
      if (out_fire)   tag_rd <= tag_rd + AW'(1);
      tag_cnt <= tag_cnt + CW'(issue_fire) - CW'(out_fire);
    end
  end

  always_ff @(posedge clk_i) begin
    if (issue_fire) begin
      tag_mem[tag_wr]  <= issue_tag_i;
      mask_mem[tag_wr] <= issue_mask_i;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr;
    logic [AW-1:0]     rd;
    logic [CW-1:0]     cnt;
    logic              ahead;
    logic              push;

    // A lane may never hold more results than there are issued ops.
    assign ahead           = (cnt >= tag_cnt);
    assign lane_ready_o[g] = (cnt != CW'(DEPTH));
    assign push            = lane_valid_i[g] & lane_ready_o[g] & ~ahead;
    assign lane_bad[g]     = lane_valid_i[g] & ~push;
    assign lane_nempty[g]  = (cnt != '0);
    assign out_res_o[g*LANE_W +: LANE_W] = mem[rd];

    always_ff @(posedge clk_i) begin
      if (sync_rst_i || flush_i) begin
        wr  <= '0;
        rd  <= '0;
        cnt <= '0;
      end else begin
        if (push)     wr <= wr + AW'(1);
        if (out_fire) rd <= rd + AW'(1);
        cnt <= cnt + CW'(push) - CW'(out_fire);
      end
    end

    always_ff @(posedge clk_i) begin
      if (push) mem[wr] <= lane_res_i[g*LANE_W +: LANE_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i)
      err_o <= 1'b0;
    else if (!flush_i && |lane_bad)
      err_o <= 1'b1;
  end

endmodule

// File: tb/tb_vproc_fpu_lane_join.sv
// tb_vproc_fpu_lane_join: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_vproc_fpu_lane_join;

  logic        clk = 1'b0;
  logic        sync_rst;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [15:0] issue_tag;
  logic [7:0]  issue_mask;
  logic [1:0]  lane_valid;
  logic [1:0]  lane_ready;
  logic [63:0] lane_res;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_tag;
  logic [63:0] out_res;
  logic [7:0]  out_mask;
  logic [2:0]  inflight;
  logic        err;

  int tests = 0;
  int fails = 0;

  vproc_fpu_lane_join dut (
    .clk_i(clk), .sync_rst_i(sync_rst), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_tag_i(issue_tag), .issue_mask_i(issue_mask),
    .lane_valid_i(lane_valid), .lane_ready_o(lane_ready),
    .lane_res_i(lane_res),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_tag_o(out_tag), .out_res_o(out_res),
    .out_mask_o(out_mask), .inflight_o(inflight), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; issue_valid = 0; issue_tag = '0;
    issue_mask = '0; lane_valid = '0; lane_res = '0;
    out_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    sync_rst = 1;
    step(); step();
    sync_rst = 0;
  endtask

  task automatic issue(input logic [15:0] t, input logic [7:0] m);
    issue_valid = 1; issue_tag = t; issue_mask = m;
    step();
    issue_valid = 0;
  endtask

  task automatic push(input logic [1:0] v, input logic [31:0] r1,
                      input logic [31:0] r0);
    lane_valid = v; lane_res = {r1, r0};
    step();
    lane_valid = '0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({out_valid, issue_ready, lane_ready, inflight, err} !==
        {1'b0, 1'b1, 2'b11, 3'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset: v=%b ir=%b lr=%b inf=%0d err=%b want 0 1 11 0 0",
               out_valid, issue_ready, lane_ready, inflight, err);
    end
  endtask

  task automatic test_latency();
    do_reset();
    issue(16'h0011, 8'hFF);
    push(2'b01, 32'h0, 32'h3F800000);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL latency_early[%0d]: out_valid=%b want 0", i, out_valid);
      end
      if (i < 3) step();
    end
    push(2'b10, 32'h40000000, 32'h0);
    tests++;
    if ({out_valid, out_tag, out_res} !==
        {1'b1, 16'h0011, 64'h40000000_3F800000}) begin
      fails++;
      $display("FAIL latency_join: v=%b tag=%h res=%h want 1 0011 400000003f800000",
               out_valid, out_tag, out_res);
    end
    out_ready = 1; step(); out_ready = 0;
    tests++;
    if (inflight !== 3'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_drain: inf=%0d v=%b want 0 0", inflight, out_valid);
    end
  endtask

  task automatic test_credit();
    do_reset();
    for (int i = 0; i < 4; i++) issue(16'h0100 + 16'(i), 8'(i));
    tests++;
    if (inflight !== 3'd4 || issue_ready !== 1'b0) begin
      fails++;
      $display("FAIL credit_full: inf=%0d ir=%b want 4 0", inflight, issue_ready);
    end
    for (int i = 0; i < 4; i++) push(2'b11, 32'hB0 + i, 32'hA0 + i);
    tests++;
    if (out_valid !== 1'b1 || out_tag !== 16'h0100) begin
      fails++;
      $display("FAIL credit_head: v=%b tag=%h want 1 0100", out_valid, out_tag);
    end
    out_ready = 1; step(); out_ready = 0;
    tests++;
    if (inflight !== 3'd3 || issue_ready !== 1'b1 || out_tag !== 16'h0101
        || out_res !== {32'hB1, 32'hA1}) begin
      fails++;
      $display("FAIL credit_pop: inf=%0d ir=%b tag=%h res=%h want 3 1 0101 000000b1000000a1",
               inflight, issue_ready, out_tag, out_res);
    end
    out_ready = 1; step(); step(); step(); out_ready = 0;
    tests++;
    if (inflight !== 3'd0) begin
      fails++;
      $display("FAIL credit_drain: inf=%0d want 0", inflight);
    end
  endtask

  task automatic test_simul();
    do_reset();
    issue(16'h0031, 8'h01);
    issue(16'h0032, 8'h02);
    push(2'b11, 32'h11, 32'h10);
    push(2'b11, 32'h21, 32'h20);
    issue_valid = 1; issue_tag = 16'h0033; issue_mask = 8'h03;
    out_ready = 1;
    step();
    issue_valid = 0; out_ready = 0;
    tests++;
    if (inflight !== 3'd2 || out_tag !== 16'h0032 || out_mask !== 8'h02) begin
      fails++;
      $display("FAIL simul: inf=%0d tag=%h mask=%h want 2 0032 02",
               inflight, out_tag, out_mask);
    end
    push(2'b11, 32'h31, 32'h30);
    out_ready = 1; step();
    tests++;
    if (out_tag !== 16'h0033 || out_res !== {32'h31, 32'h30}) begin
      fails++;
      $display("FAIL simul_tail: tag=%h res=%h want 0033 0000003100000030",
               out_tag, out_res);
    end
    step(); out_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] tags[$];
    logic [63:0] ress[$];
    logic [7:0]  masks[$];
    do_reset();
    issue(16'h0041, 8'hA1);
    issue(16'h0042, 8'hA2);
    issue(16'h0043, 8'hA3);
    out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      lane_valid = {(i == 0 || i == 3 || i == 6), (i < 3)};
      lane_res = {32'hB0 + 32'(i / 3), 32'hA0 + 32'(i)};
      step();
      lane_valid = '0;
      if (out_valid) begin
        tags.push_back(out_tag);
        ress.push_back(out_res);
        masks.push_back(out_mask);
      end
    end
    out_ready = 0;
    tests++;
    if (tags.size() != 3 || inflight !== 3'd0) begin
      fails++;
      $display("FAIL b2b_count: beats=%0d inf=%0d want 3 0", tags.size(), inflight);
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (tags[k] !== 16'h0041 + 16'(k) || masks[k] !== 8'hA1 + 8'(k)
            || ress[k] !== {32'hB0 + 32'(k), 32'hA0 + 32'(k)}) begin
          fails++;
          $display("FAIL b2b_beat%0d: tag=%h mask=%h res=%h", k,
                   tags[k], masks[k], ress[k]);
        end
      end
    end
  endtask

  task automatic test_err();
    do_reset();
    push(2'b10, 32'hDEAD, 32'h0);
    tests++;
    if (err !== 1'b1 || lane_ready !== 2'b11) begin
      fails++;
      $display("FAIL err_set: err=%b lr=%b want 1 11", err, lane_ready);
    end
    issue(16'h0051, 8'h0F);
    push(2'b01, 32'h0, 32'h5);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL err_dropped: out_valid=%b want 0", out_valid);
    end
    flush = 1; step(); flush = 0;
    tests++;
    if (err !== 1'b1 || inflight !== 3'd0) begin
      fails++;
      $display("FAIL err_flush: err=%b inf=%0d want 1 0", err, inflight);
    end
    sync_rst = 1; step(); sync_rst = 0;
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: err=%b want 0", err);
    end
  endtask

  task automatic test_flush();
    do_reset();
    issue(16'h0061, 8'h01);
    issue(16'h0062, 8'h02);
    issue(16'h0063, 8'h03);
    push(2'b11, 32'h1, 32'h2);
    push(2'b01, 32'h0, 32'h3);
    flush = 1; issue_valid = 1; issue_tag = 16'h0064;
    lane_valid = 2'b10; out_ready = 1;
    step();
    idle();
    tests++;
    if ({inflight, out_valid, issue_ready, lane_ready, err} !==
        {3'd0, 1'b0, 1'b1, 2'b11, 1'b0}) begin
      fails++;
      $display("FAIL flush: inf=%0d v=%b ir=%b lr=%b err=%b want 0 0 1 11 0",
               inflight, out_valid, issue_ready, lane_ready, err);
    end
    issue(16'h0070, 8'h70);
    push(2'b11, 32'h71, 32'h70);
    tests++;
    if (out_valid !== 1'b1 || out_tag !== 16'h0070 || out_res !== {32'h71, 32'h70}) begin
      fails++;
      $display("FAIL flush_fresh: v=%b tag=%h res=%h want 1 0070 0000007100000070",
               out_valid, out_tag, out_res);
    end
  endtask

  task automatic test_random();
    logic [15:0] tq[$];
    logic [7:0]  mq[$];
    logic [31:0] l0[$];
    logic [31:0] l1[$];
    logic        ev, iv, ordy, fl, p0, p1, ifire, ofire;
    logic [31:0] r0, r1;
    int          bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 1500; c++) begin
      ev = (tq.size() > 0) && (l0.size() > 0) && (l1.size() > 0);
      tests++;
      if (out_valid !== ev || inflight !== 3'(tq.size())
          || issue_ready !== (tq.size() < 4)
          || lane_ready !== {l1.size() < 4, l0.size() < 4}
          || (ev && (out_tag !== tq[0] || out_mask !== mq[0]
                     || out_res !== {l1[0], l0[0]}))) begin
        fails++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_cyc%0d: v=%b inf=%0d tag=%h res=%h want v=%b inf=%0d",
                   c, out_valid, inflight, out_tag, out_res, ev, tq.size());
      end
      iv   = ($urandom_range(0, 99) < 45);
      ordy = ($urandom_range(0, 99) < 40);
      fl   = ($urandom_range(0, 99) < 2);
      p0   = ($urandom_range(0, 99) < 50) && (l0.size() < tq.size());
      p1   = ($urandom_range(0, 99) < 30) && (l1.size() < tq.size());
      r0   = $urandom();
      r1   = $urandom();
      issue_valid = iv; issue_tag = 16'($urandom());
      issue_mask = 8'($urandom()); out_ready = ordy; flush = fl;
      lane_valid = {p1, p0}; lane_res = {r1, r0};
      ifire = iv && (tq.size() < 4);
      ofire = ev && ordy;
      if (fl) begin
        tq.delete(); mq.delete(); l0.delete(); l1.delete();
      end else begin
        if (ofire) begin
          void'(tq.pop_front()); void'(mq.pop_front());
          void'(l0.pop_front()); void'(l1.pop_front());
        end
        if (ifire) begin
          tq.push_back(issue_tag); mq.push_back(issue_mask);
        end
        if (p0) l0.push_back(r0);
        if (p1) l1.push_back(r1);
      end
      step();
    end
    idle();
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL rand_err: err=%b want 0", err);
    end
  endtask

  initial begin
    sync_rst = 1;
    idle();
    test_reset();
    test_latency();
    test_credit();
    test_simul();
    test_back_to_back();
    test_err();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
